// File: rtl/onehot_pkg.sv
// onehot_pkg: shared defaults, FSM state type and error-count limit for the one-hot decoder.
package onehot_pkg;
    localparam int WID_DEF = 4;
    localparam int ONEHOT_WID_DEF = 16;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
endpackage

// File: rtl/onehot_prio_enc.sv
// onehot_prio_enc: lowest-set-bit encoder; with ONEHOT_CHECK_EN also flags zero-hot/multi-hot vectors.
module onehot_prio_enc
    import onehot_pkg::*;
#(
    parameter int WID = WID_DEF,
    parameter int ONEHOT_WID = ONEHOT_WID_DEF
) (
    input  logic [ONEHOT_WID-1:0] vec_i,
`ifdef ONEHOT_CHECK_EN
    output logic                  err_o,
`endif
    output logic [WID-1:0]        bin_o
);
    always_comb begin
        bin_o = '0;
        for (int i = ONEHOT_WID - 1; i >= 0; i--)
            if (vec_i[i]) bin_o = WID'(i);
    end
`ifdef ONEHOT_CHECK_EN
    // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
    assign err_o = (vec_i == '0) || ((vec_i & (vec_i - ONEHOT_WID'(1))) != '0);
`endif
endmodule

// File: rtl/onehot_binary_decoder.sv
// onehot_binary_decoder: one-hot to binary decoder with a 2-entry skid-buffered output.
// Define ONEHOT_CHECK_EN to enable zero-hot/multi-hot detection and the saturating err_cnt.
module onehot_binary_decoder
    import onehot_pkg::*;
#(
    parameter int WID = WID_DEF,
    parameter int ONEHOT_WID = ONEHOT_WID_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ONEHOT_WID-1:0] in_onehot,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WID-1:0]        out_bin,
    output logic                  out_err,
    output logic [7:0]            err_cnt
);
    state_e state_q, state_d;
    logic in_ready_q;
    logic [WID-1:0] main_bin_q, skid_bin_q, enc_bin;
    logic in_xfer, out_xfer, ld_main_in, ld_skid_in, ld_main_skid;

    assign in_ready  = in_ready_q;
    assign out_valid = state_q != EMPTY;
    assign out_bin   = main_bin_q;
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

`ifdef ONEHOT_CHECK_EN
    logic enc_err, main_err_q, skid_err_q;
    logic [7:0] err_cnt_q;
    onehot_prio_enc #(.WID(WID), .ONEHOT_WID(ONEHOT_WID)) u_enc (
        .vec_i(in_onehot),
        .err_o(enc_err),
        .bin_o(enc_bin)
    );
`else
    onehot_prio_enc #(.WID(WID), .ONEHOT_WID(ONEHOT_WID)) u_enc (
        .vec_i(in_onehot),
        .bin_o(enc_bin)
    );
`endif

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_skid_in   = 1'b0;
        ld_main_skid = 1'b0;
        case (state_q)
            EMPTY: if (in_xfer) begin
                ld_main_in = 1'b1;
                state_d    = ONE;
            end
            ONE: begin
                ld_main_in = in_xfer && out_xfer;
                ld_skid_in = in_xfer && !out_xfer;
                state_d    = ld_skid_in ? FULL : (out_xfer && !in_xfer) ? EMPTY : ONE;
            end
            FULL: if (out_xfer) begin
                ld_main_skid = 1'b1;
                state_d      = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    // in_ready is registered from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            main_bin_q <= '0;
            skid_bin_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != FULL;
            if (ld_main_in) main_bin_q <= enc_bin;
            else if (ld_main_skid) main_bin_q <= skid_bin_q;
            if (ld_skid_in) skid_bin_q <= enc_bin;
        end
    end

`ifdef ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            main_err_q <= 1'b0;
            skid_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (ld_main_in) main_err_q <= enc_err;
            else if (ld_main_skid) main_err_q <= skid_err_q;
            if (ld_skid_in) skid_err_q <= enc_err;
            if (in_xfer && enc_err && err_cnt_q != ERR_CNT_MAX) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end
    assign out_err = main_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign out_err = 1'b0;
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_onehot_binary_decoder.sv
// tb_onehot_binary_decoder: scoreboard bench with directed and randomized one-hot traffic.
module tb_onehot_binary_decoder;
    localparam int WID = 4;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
    logic [OW-1:0] in_onehot = '0;
    logic [WID-1:0] out_bin;
    logic [7:0] err_cnt;

    int tests = 0, fails = 0;
    logic [WID:0] exp_q[$];
    int exp_cnt = 0;
    bit rst_seen = 1'b1;

    onehot_binary_decoder #(.WID(WID), .ONEHOT_WID(OW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_onehot(in_onehot),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WID:0] model(input logic [OW-1:0] v);
        logic [OW-1:0] lsb;
        int idx;
        bit e;
        lsb = v & (~v + 1'b1);
        idx = (v == 0) ? 0 : $clog2(lsb);
`ifdef ONEHOT_CHECK_EN
        e = $countones(v) != 1;
`else
        e = 1'b0;
`endif
        return {e, WID'(idx)};
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Stimulus side: record every accepted vector as an expected result.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (in_valid && in_ready) begin
                logic [WID:0] r;
                r = model(in_onehot);
                exp_q.push_back(r);
                if (r[WID] && exp_cnt < 255) exp_cnt++;
            end
        end
    end

    // Monitor: compare the presented result against the queue head; pop on output transfer.
    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_in_ready", int'(in_ready), 0);
            check("rst_out_bin", int'(out_bin), 0);
            check("rst_out_err", int'(out_err), 0);
            check("rst_err_cnt", int'(err_cnt), 0);
        end else begin
            check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            check("in_ready", int'(in_ready), int'(exp_q.size() < 2));
            check("err_cnt", int'(err_cnt), exp_cnt);
            if (out_valid && exp_q.size() != 0) begin
                check("out_bin", int'(out_bin), int'(exp_q[0][WID-1:0]));
                check("out_err", int'(out_err), int'(exp_q[0][WID]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input bit v, input logic [OW-1:0] vec, input bit r);
        in_valid = v;
        in_onehot = vec;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, '0, 1);
        // Ready path
        step(1, 16'h0020, 1);
        step(0, 16'hffff, 1);
        step(0, '0, 1);
        // Stall into FULL; a vector offered while full must be ignored
        step(1, 16'h0001, 0);
        step(1, 16'h8000, 0);
        step(1, 16'h0040, 0);
        step(0, '0, 0);
        step(0, '0, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        // Error vectors
        step(1, 16'h0000, 1);
        step(1, 16'h0104, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        // Saturation
        repeat (300) step(1, 16'h0003, 1);
        step(0, '0, 1);
        // Reset while FULL
        step(1, 16'h0002, 0);
        step(1, 16'h0300, 0);
        step(0, '0, 0);
        rst = 1'b1;
        step(0, '0, 0);
        rst = 1'b0;
        step(0, '0, 1);
        step(0, '0, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [OW-1:0] vec;
            int k;
            k = $urandom_range(0, 9);
            vec = (k < 6) ? (OW'(1) << $urandom_range(0, OW - 1)) :
                  (k == 6) ? '0 : OW'($urandom);
            step($urandom_range(0, 3) != 0, vec, $urandom_range(0, 2) != 0);
        end
        repeat (4) step(0, '0, 1);
        check("drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/onehot_binary_decoder.md
ONEHOT_BINARY_DECODER -- requirements
Module: onehot_binary_decoder

Interface
REQ-001 Parameter WID, default 4, binary index width.
REQ-002 Parameter ONEHOT_WID, default 16, one-hot vector width; SHALL equal 2**WID.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_onehot holds a valid vector this cycle.
REQ-006 in_ready  output  1  block accepts a vector this cycle; driven from a register.
REQ-007 in_onehot  input  ONEHOT_WID  one-hot vector from the binary-to-one-hot stage.
REQ-008 out_valid  output  1  out_bin/out_err hold a valid result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 out_bin  output  WID  decoded binary index.
REQ-011 out_err  output  1  the source vector was zero-hot or multi-hot.
REQ-012 err_cnt  output  8  saturating count of erroneous vectors accepted.

Function
REQ-013 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-014 Decode: out_bin SHALL be the index of the lowest set bit of the accepted vector; 0 for an all-zero vector.
REQ-015 Latency SHALL be exactly 1 cycle from an accepted input to out_valid when the output register is empty.
REQ-016 Buffering SHALL use a main output register plus one skid register; total capacity 2 results.
REQ-017 FSM states: EMPTY (no results), ONE (main register valid), FULL (main and skid valid).
REQ-018 EMPTY: input transfer -> ONE; otherwise stay.
REQ-019 ONE: input only -> FULL when output is stalled, stay ONE when both transfers occur; output only -> EMPTY; neither -> stay.
REQ-020 FULL: in_ready=0; output transfer moves the skid into main -> ONE; otherwise stay.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, and 0 in FULL.
REQ-022 Results SHALL leave in acceptance order; none are dropped or duplicated.
REQ-023 out_bin and out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 in_onehot SHALL be ignored when in_valid=0, and err_cnt SHALL NOT change on it.

Reset
REQ-025 rst=1 SHALL force state EMPTY and set out_valid=0, in_ready=0, out_bin=0, out_err=0, err_cnt=0.
REQ-026 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-027 rst asserted mid-operation SHALL discard both buffered results with no output transfer.

Configuration
REQ-028 Macro ONEHOT_CHECK_EN, when defined, SHALL enable error detection.
REQ-029 With ONEHOT_CHECK_EN, out_err=1 iff the accepted vector's popcount != 1.
REQ-030 With ONEHOT_CHECK_EN, err_cnt SHALL increment on each accepted erroneous vector and saturate at 255.
REQ-031 Without ONEHOT_CHECK_EN, out_err and err_cnt SHALL be constant 0, with no detection logic; decode is unchanged.

Structure
REQ-032 Package onehot_pkg SHALL hold the WID/ONEHOT_WID defaults, the FSM state enum and the ERR_CNT_MAX constant.
REQ-033 Sub-module onehot_prio_enc SHALL implement the combinational lowest-set-bit encoder and the validity check, instantiated once on the input side.

Verification
REQ-034 Ready path: in_onehot=16'h0020 with out_ready=1 -> next cycle out_valid=1, out_bin=5, out_err=0.
REQ-035 Stall: out_ready=0 with back-to-back 16'h0001 then 16'h8000 -> FULL and in_ready=0; then out_ready=1 -> out_bin=0, then 15, in order.
REQ-036 Error: 16'h0000 -> out_bin=0, out_err=1; 16'h0104 -> out_bin=2, out_err=1; err_cnt=2 (ONEHOT_CHECK_EN defined).
REQ-037 Saturation: 300 consecutive 16'h0003 vectors -> err_cnt holds at 255; without ONEHOT_CHECK_EN, err_cnt=0 and out_err=0 throughout.
REQ-038 Reset mid-stream: rst asserted while in FULL -> next cycle out_valid=0, err_cnt=0; in_ready=1 one cycle after release.
